// File: rtl/wb_streamer_pkg.sv
// Shared definitions for the Wishbone stream writer controller.
// Holds the controller state encoding and the Wishbone cycle-type codes
// driven on wbm_cti_o.
package wb_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_stream_writer_ctrl_if.sv
// Wishbone master bus bundle used by the stream writer controller.
// master modport: the controller (drives address/control, receives
//                 read data and ack/err/rty).
// slave modport : the bus target / memory model.
interface wb_stream_writer_ctrl_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic               wbm_we_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic [2:0]         wbm_cti_o;
  logic [1:0]         wbm_bte_o;
  logic [WB_DW-1:0]   wbm_dat_i;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic               wbm_rty_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o,
           wbm_stb_o, wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o,
           wbm_stb_o, wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone stream writer controller.
// Reads a buffer of buf_size words starting at start_adr using incrementing
// Wishbone read bursts and pushes every returned word into an external
// stream FIFO. A burst is only issued once the FIFO has room for all its
// beats, so no returned word is ever dropped.
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   wbm                 Wishbone master bundle (master modport)
//   fifo_d, fifo_wr     FIFO write data / strobe (same cycle as ack)
//   fifo_cnt            FIFO fill level in words
//   enable              start pulse; start_adr/buf_size/burst_size sampled with it
//   busy                transfer in progress
module wb_stream_writer_ctrl
  import wb_streamer_pkg::*;
#(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_stream_writer_ctrl_if.master wbm,
  output logic [WB_DW-1:0]       fifo_d,
  output logic                   fifo_wr,
  input  logic [FIFO_AW:0]       fifo_cnt,
  input  logic                   enable,
  input  logic [WB_AW-1:0]       start_adr,
  input  logic [WB_AW-1:0]       buf_size,
  input  logic [WB_AW-1:0]       burst_size,
  output logic                   busy
);

  // Wide enough to hold the FIFO depth, the fill level and any beat count
  // without overflow when computing free space.
  localparam int CW = WB_AW + FIFO_AW + 2;
  localparam logic [CW-1:0]    DEPTH_EXT = CW'(2**FIFO_AW);
  localparam logic [WB_AW-1:0] ONE_AW    = WB_AW'(1);
  localparam logic [WB_AW-1:0] TWO_AW    = WB_AW'(2);
  localparam logic [WB_AW-1:0] ADR_STEP  = WB_AW'(WB_DW/8);

  state_e           state_q;
  logic [WB_AW-1:0] adr_q;
  logic [WB_AW-1:0] remaining_q;
  logic [WB_AW-1:0] burst_max_q;
  logic [WB_AW-1:0] beat_cnt_q;
  logic             cyc_q;
  logic             stb_q;
  logic [2:0]       cti_q;
  logic             busy_q;

  logic [WB_AW-1:0] beats_s;
  logic [CW-1:0]    cnt_ext_s;
  logic [CW-1:0]    beats_ext_s;
  logic             room_ok_s;
  logic             ack_ok_s;

  // Next burst length and FIFO room test; a retry or error never counts as an ack.
  always_comb begin
    beats_s     = (burst_max_q < remaining_q) ? burst_max_q : remaining_q;
    cnt_ext_s   = CW'(fifo_cnt);
    beats_ext_s = CW'(beats_s);
    // Guard against a fill level above depth so the subtraction cannot wrap.
    room_ok_s   = (cnt_ext_s <= DEPTH_EXT) && ((DEPTH_EXT - cnt_ext_s) >= beats_ext_s);
    ack_ok_s    = (state_q == ST_BURST) && wbm.wbm_ack_i && !wbm.wbm_err_i && !wbm.wbm_rty_i;
  end

  // Controller FSM with registered bus outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      remaining_q <= '0;
      burst_max_q <= '0;
      beat_cnt_q  <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cti_q       <= CTI_CLASSIC;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && (buf_size != '0)) begin
            adr_q       <= start_adr;
            remaining_q <= buf_size;
            burst_max_q <= (burst_size == '0) ? ONE_AW : burst_size;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (room_ok_s) begin
            beat_cnt_q <= beats_s;
            cyc_q      <= 1'b1;
            stb_q      <= 1'b1;
            cti_q      <= (beats_s == ONE_AW) ? CTI_EOB : CTI_INC;
            state_q    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (wbm.wbm_err_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (ack_ok_s) begin
            adr_q       <= adr_q + ADR_STEP;
            remaining_q <= remaining_q - ONE_AW;
            beat_cnt_q  <= beat_cnt_q - ONE_AW;
            if (beat_cnt_q == ONE_AW) begin
              cyc_q <= 1'b0;
              stb_q <= 1'b0;
              cti_q <= CTI_CLASSIC;
              if (remaining_q == ONE_AW) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_WAIT;
              end
            end else begin
              // The beat following this ack is the last one when two remain.
              cti_q <= (beat_cnt_q == TWO_AW) ? CTI_EOB : CTI_INC;
            end
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          cti_q   <= CTI_CLASSIC;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = '0;
  assign wbm.wbm_sel_o = '1;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_cti_o = cti_q;
  assign wbm.wbm_bte_o = 2'b00;

  // Returned data goes straight to the FIFO in the ack cycle.
  assign fifo_d  = wbm.wbm_dat_i;
  assign fifo_wr = ack_ok_s;
  assign busy    = busy_q;

endmodule

// File: doc/wb_stream_writer_ctrl.md
WB_STREAM_WRITER_CTRL -- requirements
Module: wb_stream_writer_ctrl

Interface
REQ-001 Parameters SHALL be: WB_AW, 32, address width. WB_DW, 32, data width. FIFO_AW, 5, log2 of downstream FIFO depth.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbm_adr_o  out  WB_AW  master address
- wbm_dat_o  out  WB_DW  write data, tied 0
- wbm_sel_o  out  WB_DW/8  byte selects, all ones
- wbm_we_o  out  1  tied 0
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type, tied 2'b00
- wbm_dat_i  in  WB_DW  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry
- fifo_d  out  WB_DW  data to stream FIFO
- fifo_wr  out  1  FIFO write strobe
- fifo_cnt  in  FIFO_AW+1  current FIFO fill level, in words
- enable  in  1  single-cycle start pulse
- start_adr  in  WB_AW  buffer byte address
- buf_size  in  WB_AW  buffer length, in words
- burst_size  in  WB_AW  maximum burst length, in words
- busy  out  1  transfer in progress

Function
REQ-004 FSM SHALL have states IDLE, WAIT and BURST.
REQ-005 In IDLE, when enable=1 and buf_size!=0: latch adr=start_adr, remaining=buf_size and burst_max=max(burst_size,1), then go to WAIT with busy=1 from the next cycle.
REQ-006 In IDLE, enable with buf_size=0 SHALL be ignored; busy stays 0.
REQ-007 enable SHALL be ignored outside IDLE; start_adr, buf_size and burst_size are sampled only on an accepted enable.
REQ-008 In WAIT: compute beats=min(burst_max,remaining); when (2**FIFO_AW - fifo_cnt) >= beats, load the beat counter and go to BURST.
REQ-009 In BURST: wbm_cyc_o=wbm_stb_o=1 and wbm_adr_o=adr.
REQ-010 wbm_cti_o SHALL be 3'b010 on all beats except the last, and 3'b111 on the last beat; a 1-beat burst SHALL use 3'b111 only.
REQ-011 On each wbm_ack_i in BURST: fifo_wr=1 and fifo_d=wbm_dat_i in the same cycle (combinational); adr += WB_DW/8; remaining and the beat counter each decrement by 1.
REQ-012 On the last ack: deassert cyc and stb in the next cycle; go to IDLE with busy=0 if remaining reaches 0, else go to WAIT.
REQ-013 wbm_rty_i SHALL be treated as no ack: hold stb and address, no FIFO write.
REQ-014 wbm_err_i in BURST SHALL abort: no FIFO write, cyc and stb drop next cycle, go to IDLE, busy=0.
REQ-015 Address arithmetic SHALL be modulo 2**WB_AW; wrap is silent.
REQ-016 fifo_wr SHALL never be asserted outside BURST.

Reset
REQ-017 Asserting wb_rst_i SHALL immediately force: IDLE, busy=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_cti_o=0, wbm_adr_o=0, and internal counters to 0.
REQ-018 Reset mid-burst SHALL abandon the transfer; a burst SHALL NOT resume after reset release.

Structure
REQ-019 Package wb_streamer_pkg SHALL hold the state encoding and the CTI constants (CLASSIC=000, INC=010, EOB=111).
REQ-020 The block SHALL be one module with no sub-modules; the FIFO is external.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- start_adr=0x100, buf_size=8, burst_size=4, FIFO empty, ack every cycle -> two 4-beat bursts at 0x100 and 0x110; CTI 010,010,010,111; 8 fifo_wr; busy falls one cycle after the last ack.
- buf_size=5, burst_size=4 -> bursts of 4 then 1; the second burst starts at +0x10 with CTI 111.
- FIFO_AW=5, fifo_cnt=30, burst_size=4 -> stays in WAIT, cyc=0; fifo_cnt=28 -> burst starts.
- wbm_err_i on beat 2 -> one fifo_wr only, cyc drops, busy=0; a new enable then restarts at start_adr.
- rty on beat 1 for 3 cycles -> address held, no writes; the burst then completes normally.
- wb_rst_i asserted mid-burst -> cyc and busy are 0 with no clock edge; enable with buf_size=0 -> busy stays 0.
